// File: rtl/pixel_streamer.sv
// pixel_streamer: holds one frame of 8-bit pixels written by the host and
// streams it row-major, one pixel per cycle, into the DNN top's pixel_in/valid_in.
// After the last pixel, it waits idle so the downstream pipeline can drain,
// then pulses done.
//
// Optional feature macro: PIXEL_STREAMER_ZERO_POINT_EN
//   defined   : pixel_out = stored byte - 128 (zero-point shift to signed)
//   undefined : pixel_out = stored byte reinterpreted as signed
//
// MAX_DIM is limited to 16 because the host write address is 8 bits wide.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; host may write the frame buffer
// STREAM | issuing read addresses; beats emerge two cycles behind
// FLUSH  | last beat on the bus, then idle cycles so the pipeline drains
// DONE   | one-cycle done pulse; start or host writes accepted as in IDLE
module pixel_streamer #(
    parameter int MAX_DIM      = 16,
    parameter int FLUSH_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_height,
    input  logic              start,
    output logic signed [7:0] pixel_out,
    output logic              valid_out,
    output logic [7:0]        img_width,
    output logic [7:0]        img_height,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [7:0]    MAX_D8    = 8'(MAX_DIM);
    localparam logic [15:0]   DEPTH16   = 16'(DEPTH);
    localparam logic [FW-1:0] FLUSH_TOP = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      rd_data;
    logic [15:0]     rd_addr;
    logic [15:0]     frame_last;
    logic [15:0]     area;
    logic            rd_active;
    logic            rd_vld;
    logic            rd_last;
    logic [FW-1:0]   flush_cnt;
    logic            start_ok;
    logic            dims_ok;
    logic            wr_ok;
    logic            accepting;
    logic signed [7:0] pix_conv;

    assign accepting = (state == IDLE) || (state == DONE);
    assign wr_ok     = wr_en && accepting && ({8'd0, wr_addr} < DEPTH16);
    assign dims_ok   = (cfg_width  >= 8'd3) && (cfg_width  <= MAX_D8) &&
                       (cfg_height >= 8'd3) && (cfg_height <= MAX_D8);
    assign area      = {8'd0, cfg_width} * {8'd0, cfg_height};

`ifdef PIXEL_STREAMER_ZERO_POINT_EN
    assign pix_conv = rd_data - 8'd128;
`else
    assign pix_conv = rd_data;
`endif

    // Frame buffer: synchronous write from the host, registered read for the streamer.
    // Contents deliberately survive reset so a frame can be replayed after an abort.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[AW-1:0]];
    end

    // Control FSM plus read pipeline; outputs are all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            frame_last <= '0;
            rd_active  <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            flush_cnt  <= '0;
            start_ok   <= 1'b0;
            pixel_out  <= '0;
            valid_out  <= 1'b0;
            img_width  <= '0;
            img_height <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // start is ignored in the first cycle after reset release
            start_ok  <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;

            rd_vld    <= rd_active;
            rd_last   <= rd_active && (rd_addr == frame_last);
            valid_out <= rd_vld;
            pixel_out <= rd_vld ? pix_conv : 8'sd0;

            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start && start_ok) begin
                        if (dims_ok) begin
                            img_width  <= cfg_width;
                            img_height <= cfg_height;
                            frame_last <= area - 16'd1;
                            rd_addr    <= '0;
                            rd_active  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= STREAM;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (rd_active) begin
                        if (rd_addr == frame_last) begin
                            rd_active <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + 16'd1;
                        end
                    end
                    // the last beat is registered onto the bus at this edge
                    if (rd_last) begin
                        flush_cnt <= FLUSH_TOP;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer (default parameters MAX_DIM=16, FLUSH_CYCLES=20).
// Expected pixel values follow PIXEL_STREAMER_ZERO_POINT_EN the same way the DUT build does.
module tb_pixel_streamer;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        cfg_width;
    logic [7:0]        cfg_height;
    logic              start;
    logic signed [7:0] pixel_out;
    logic              valid_out;
    logic [7:0]        img_width;
    logic [7:0]        img_height;
    logic              busy;
    logic              done;
    logic              frame_err;

    pixel_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .start      (start),
        .pixel_out  (pixel_out),
        .valid_out  (valid_out),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int model [256];
    int cap   [256];
    int r_first, r_last, r_beats, r_done, r_bad;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_pix(input int v);
`ifdef PIXEL_STREAMER_ZERO_POINT_EN
        return v - 128;
`else
        return (v >= 128) ? v - 256 : v;
`endif
    endfunction

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    // start a frame and watch it until done; optional mid-stream start+write at inject_k
    task automatic run_frame(input int w, input int h, input int inject_k);
        int n;
        n = w * h;
        r_first = -1; r_last = -1; r_beats = 0; r_done = -1; r_bad = 0;
        cfg_width = 8'(w); cfg_height = 8'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_latency", int'(busy), 1);
        for (int k = 0; k < n + 60; k++) begin
            if (valid_out) begin
                if (r_first < 0) r_first = k;
                if (r_beats < 256) cap[r_beats] = int'(pixel_out);
                if (r_beats < n && int'(pixel_out) != exp_pix(model[r_beats])) r_bad++;
                r_beats++;
                r_last = k;
            end
            if (done) begin
                r_done = k;
                break;
            end
            if (k == inject_k) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hAA;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int n);
        chk({tag, "_first_beat"}, r_first, 2);
        chk({tag, "_beats"}, r_beats, n);
        chk({tag, "_last_beat"}, r_last, n + 1);
        chk({tag, "_done_cycle"}, r_done, n + 21);
        chk({tag, "_bad_pixels"}, r_bad, 0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic err_test(input int w, input int h, input string tag);
        int v, b, e;
        v = 0; b = 0; e = 0;
        cfg_width = 8'(w); cfg_height = 8'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_frame_err"}, int'(frame_err), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid_out) v++;
            if (busy) b++;
            if (frame_err) e++;
        end
        chk({tag, "_valid_cnt"}, v, 0);
        chk({tag, "_busy_cnt"}, b, 0);
        chk({tag, "_err_width"}, e, 0);
        chk({tag, "_img_w_kept"}, int'(img_width), 8);
        chk({tag, "_img_h_kept"}, int'(img_height), 8);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int beats, first2, last1, bad, gap, ch;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_width = 8'd8; cfg_height = 8'd8; start = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_pixel", int'(pixel_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_img_w", int'(img_width), 0);
        chk("rst_img_h", int'(img_height), 0);

        // start in the first cycle after reset release is ignored
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_rst_ignored", int'(busy), 0);
        @(negedge clk);
        chk("start_after_rst_idle", int'(busy), 0);

        // 8x8 frame of 0..63
        for (int i = 0; i < 64; i++) wr(i, i);
        run_frame(8, 8, -1);
        chk("f8_img_w", int'(img_width), 8);
        chk("f8_img_h", int'(img_height), 8);
`ifdef PIXEL_STREAMER_ZERO_POINT_EN
        chk("f8_first_px", cap[0], -128);
        chk("f8_last_px", cap[63], -65);
`else
        chk("f8_first_px", cap[0], 0);
        chk("f8_last_px", cap[63], 63);
`endif
        check_frame("f8", 64);

        // out-of-range dimensions
        err_test(2, 8, "w2");
        err_test(17, 8, "w17");

        // start and write while streaming are ignored
        run_frame(8, 8, 20);
        check_frame("inj", 64);
        repeat (5) @(negedge clk);
        chk("inj_no_restart", int'(busy), 0);

        // reset at beat 10, then replay
        cfg_width = 8'd8; cfg_height = 8'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid_out) beats++;
            if (beats == 10) break;
            @(negedge clk);
        end
        chk("rst_mid_beats_seen", beats, 10);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(valid_out), 0);
        chk("rst_mid_pixel", int'(pixel_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_img_w", int'(img_width), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(8, 8, -1);
        chk("replay_addr5", cap[5], exp_pix(5));
        check_frame("replay", 64);

        // pixel conversion corner values on a 3x3 frame
        wr(0, 255); wr(1, 200); wr(2, 128); wr(3, 0); wr(4, 1);
        wr(5, 127); wr(6, 254); wr(7, 64); wr(8, 3);
        run_frame(3, 3, -1);
`ifdef PIXEL_STREAMER_ZERO_POINT_EN
        chk("px_255", cap[0], 127);
        chk("px_200", cap[1], 72);
        chk("px_128", cap[2], 0);
        chk("px_0", cap[3], -128);
`else
        chk("px_255", cap[0], -1);
        chk("px_200", cap[1], -56);
        chk("px_128", cap[2], -128);
        chk("px_0", cap[3], 0);
`endif
        check_frame("f3", 9);

        // 3x16 frames back to back, second start in the DONE cycle
        for (int i = 0; i < 48; i++) wr(i, (i * 5 + 7) % 256);
        cfg_width = 8'd3; cfg_height = 8'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0; first2 = -1; last1 = -1; bad = 0; ch = 0;
        for (int k = 0; k < 200; k++) begin
            if (valid_out) begin
                if (int'(pixel_out) != exp_pix(model[beats % 48])) bad++;
                if (beats == 47) last1 = k;
                if (beats == 48) first2 = k;
                beats++;
            end
            if (beats == 96) break;
            if (done && ch == 0) begin
                start = 1'b1; ch = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        gap = first2 - last1 - 1;
        chk("b2b_beats", beats, 96);
        chk("b2b_last1", last1, 49);
        chk("b2b_gap", gap, 22);
        chk("b2b_bad_pixels", bad, 0);
        chk("b2b_img_h", int'(img_height), 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
